// File: rtl/alu_exec_unit_pkg.sv
// Shared types for the RV64I execute stage: op classes, decoded ALU ops,
// and the registered output bundle.
package alu_exec_unit_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_RTYPE  = 2'b10,
    OP_ITYPE  = 2'b11
  } alu_op_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_ctr_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] result;
    logic            zero;
    alu_ctr_t        ctrl;
  } ex_out_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/alu_exec_unit_decode.sv
// ALU control decode: op class, funct3 and funct7[5] to a decoded ALU op.
// Purely combinational.
module alu_exec_unit_decode
  import alu_exec_unit_pkg::*;
(
  input  logic [1:0] ctrl_alu_op,
  input  logic [2:0] funct3,
  input  logic       f7_5,
  output alu_ctr_t   alu_ctrl
);

  alu_op_t op;

  assign op = alu_op_t'(ctrl_alu_op);

  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (op)
      OP_ADD: alu_ctrl = ALU_ADD;
      OP_BRANCH: begin
        case (funct3)
          3'b001:  alu_ctrl = ALU_BNE;
          3'b100:  alu_ctrl = ALU_BLT;
          3'b101:  alu_ctrl = ALU_BGE;
          3'b110:  alu_ctrl = ALU_BLTU;
          3'b111:  alu_ctrl = ALU_BGEU;
          default: alu_ctrl = ALU_BEQ;
        endcase
      end
      OP_RTYPE, OP_ITYPE: begin
        case (funct3)
          // No SUBI: immediate form of funct3=000 is always ADD
          3'b000: alu_ctrl = (op == OP_RTYPE && f7_5)
                             ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctrl = ALU_SLL;
          3'b010: alu_ctrl = ALU_SLT;
          3'b011: alu_ctrl = ALU_SLTU;
          3'b100: alu_ctrl = ALU_XOR;
          3'b101: alu_ctrl = f7_5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// RV64I execute stage: decode, 64/32-bit datapath, branch flag,
// and a single output register stage (one cycle latency).
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [1:0]      ctrl_alu_op,
  input  logic            word,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] data_a,
  input  logic [XLEN-1:0] data_b,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl
);

  alu_ctr_t        ctrl;
  logic            w_en;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] r64;
  logic [31:0]     r32;
  logic [XLEN-1:0] res;
  logic            taken;
  logic            is_br;
  ex_out_t         d;
  ex_out_t         q;
  logic            unused_f7;

  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  alu_exec_unit_decode u_decode (
    .ctrl_alu_op (ctrl_alu_op),
    .funct3      (funct3),
    .f7_5        (funct7[5]),
    .alu_ctrl    (ctrl)
  );

  // Word mode only exists for R/I-type classes
  assign w_en = word & ctrl_alu_op[1];
  assign diff = data_a - data_b;

  always_comb begin
    r64 = diff;
    unique case (ctrl)
      ALU_ADD:  r64 = data_a + data_b;
      ALU_SUB:  r64 = diff;
      ALU_SLL:  r64 = data_a << data_b[5:0];
      ALU_SLT:  r64 = {63'b0, $signed(data_a) < $signed(data_b)};
      ALU_SLTU: r64 = {63'b0, data_a < data_b};
      ALU_XOR:  r64 = data_a ^ data_b;
      ALU_SRL:  r64 = data_a >> data_b[5:0];
      ALU_SRA:  r64 = $signed(data_a) >>> data_b[5:0];
      ALU_OR:   r64 = data_a | data_b;
      ALU_AND:  r64 = data_a & data_b;
      default:  r64 = diff;
    endcase
  end

  // Only shifts differ in their low word; everything else reuses r64
  always_comb begin
    r32 = r64[31:0];
    unique case (ctrl)
      ALU_SLL: r32 = data_a[31:0] << data_b[4:0];
      ALU_SRL: r32 = data_a[31:0] >> data_b[4:0];
      ALU_SRA: r32 = $signed(data_a[31:0]) >>> data_b[4:0];
      default: r32 = r64[31:0];
    endcase
  end

  assign res = w_en ? sext32(r32) : r64;

  always_comb begin
    taken = 1'b0;
    is_br = 1'b1;
    unique case (ctrl)
      ALU_BEQ:  taken = (data_a == data_b);
      ALU_BNE:  taken = (data_a != data_b);
      ALU_BLT:  taken = $signed(data_a) < $signed(data_b);
      ALU_BGE:  taken = $signed(data_a) >= $signed(data_b);
      ALU_BLTU: taken = data_a < data_b;
      ALU_BGEU: taken = data_a >= data_b;
      default:  is_br = 1'b0;
    endcase
  end

  always_comb begin
    d        = '0;
    d.valid  = in_valid;
    d.result = res;
    d.zero   = is_br ? taken : (res == '0);
    d.ctrl   = ctrl;
  end

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

  assign out_valid = q.valid;
  assign result    = q.result;
  assign zero      = q.zero;
  assign alu_ctrl  = q.ctrl;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expectations.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  ctrl_alu_op;
  logic        word;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] data_a;
  logic [63:0] data_b;
  logic        out_valid;
  logic [63:0] result;
  logic        zero;
  logic [3:0]  alu_ctrl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic        w;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        z;
    logic [3:0]  ctl;
  } vec_t;

  vec_t vq[$];

  alu_exec_unit dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .ctrl_alu_op (ctrl_alu_op),
    .word        (word),
    .funct3      (funct3),
    .funct7      (funct7),
    .data_a      (data_a),
    .data_b      (data_b),
    .out_valid   (out_valid),
    .result      (result),
    .zero        (zero),
    .alu_ctrl    (alu_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic w,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] a, input logic [63:0] b);
    ctrl_alu_op = op;
    word        = w;
    funct3      = f3;
    funct7      = f7;
    data_a      = a;
    data_b      = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v,
                            input logic [63:0] r, input logic z,
                            input logic [3:0] c);
    chk({tag, ".valid"},  {63'b0, out_valid}, {63'b0, v});
    chk({tag, ".result"}, result, r);
    chk({tag, ".zero"},   {63'b0, zero}, {63'b0, z});
    chk({tag, ".ctrl"},   {60'b0, alu_ctrl}, {60'b0, c});
  endtask

  task automatic vec(input logic [1:0] op, input logic w,
                     input logic [2:0] f3, input logic [6:0] f7,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] r, input logic z,
                     input logic [3:0] c);
    vec_t v;
    v.op = op; v.w = w; v.f3 = f3; v.f7 = f7;
    v.a = a; v.b = b; v.res = r; v.z = z; v.ctl = c;
    vq.push_back(v);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    drive(2'b00, 1'b0, 3'b000, 7'h00, 64'd0, 64'd0);
    tick();

    // Reset wins over in_valid
    reset    = 1'b1;
    in_valid = 1'b1;
    drive(2'b10, 1'b0, 3'b000, 7'h20, 64'd5, 64'd7);
    tick();
    expect_out("reset", 1'b0, 64'd0, 1'b0, 4'd0);

    reset = 1'b0;
    tick();
    expect_out("sub", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'd1);

    drive(2'b10, 1'b0, 3'b000, 7'h00, 64'd5, 64'd7);
    tick();
    expect_out("add", 1'b1, 64'd12, 1'b0, 4'd0);

    drive(2'b11, 1'b0, 3'b101, 7'h20, 64'h8000_0000_0000_0000, 64'd4);
    tick();
    expect_out("srai", 1'b1, 64'hF800_0000_0000_0000, 1'b0, 4'd7);

    drive(2'b11, 1'b1, 3'b101, 7'h20, 64'h0000_0000_8000_0000, 64'd4);
    tick();
    expect_out("sraiw", 1'b1, 64'hFFFF_FFFF_F800_0000, 1'b0, 4'd7);

    drive(2'b01, 1'b0, 3'b100, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    tick();
    expect_out("blt", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'd12);

    drive(2'b01, 1'b0, 3'b110, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    tick();
    expect_out("bltu", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'd14);

    drive(2'b01, 1'b0, 3'b000, 7'h00, 64'd3, 64'd3);
    tick();
    expect_out("beq", 1'b1, 64'd0, 1'b1, 4'd10);

    drive(2'b01, 1'b0, 3'b001, 7'h00, 64'd3, 64'd3);
    tick();
    expect_out("bne", 1'b1, 64'd0, 1'b0, 4'd11);

    // funct3=011 falls back to BEQ; word must be ignored for branches
    drive(2'b01, 1'b1, 3'b011, 7'h00, 64'h1_0000_0005, 64'd5);
    tick();
    expect_out("beq_alias", 1'b1, 64'h1_0000_0000, 1'b0, 4'd10);

    drive(2'b10, 1'b1, 3'b000, 7'h00, 64'h7FFF_FFFF, 64'd1);
    tick();
    expect_out("addw_wrap", 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 4'd0);

    drive(2'b00, 1'b1, 3'b111, 7'h20, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    tick();
    expect_out("add_wrap", 1'b1, 64'h8000_0000_0000_0000, 1'b0, 4'd0);

    in_valid = 1'b0;
    drive(2'b00, 1'b0, 3'b000, 7'h00, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    expect_out("idle", 1'b0, 64'd0, 1'b1, 4'd0);
    in_valid = 1'b1;

    vec(2'b10, 0, 3'b001, 7'h00, 64'd1, 64'd63,
        64'h8000_0000_0000_0000, 0, 4'd2);
    vec(2'b10, 0, 3'b001, 7'h00, 64'd1, 64'd64, 64'd1, 0, 4'd2);
    vec(2'b10, 0, 3'b010, 7'h00, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3,
        64'd1, 0, 4'd3);
    vec(2'b10, 0, 3'b011, 7'h00, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3,
        64'd0, 1, 4'd4);
    vec(2'b10, 0, 3'b100, 7'h00, 64'hF0F0, 64'hFF00, 64'h0FF0, 0, 4'd5);
    vec(2'b10, 0, 3'b101, 7'h00, 64'h8000_0000_0000_0000, 64'd63,
        64'd1, 0, 4'd6);
    vec(2'b10, 0, 3'b101, 7'h20, 64'h8000_0000_0000_0000, 64'd63,
        64'hFFFF_FFFF_FFFF_FFFF, 0, 4'd7);
    vec(2'b10, 0, 3'b110, 7'h00, 64'h00FF, 64'hFF00, 64'hFFFF, 0, 4'd8);
    vec(2'b10, 0, 3'b111, 7'h00, 64'hF0F0, 64'h0FF0, 64'h00F0, 0, 4'd9);
    vec(2'b10, 0, 3'b111, 7'h00, 64'hF0, 64'h0F, 64'd0, 1, 4'd9);
    vec(2'b11, 0, 3'b000, 7'h20, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF,
        64'd9, 0, 4'd0);
    vec(2'b11, 0, 3'b101, 7'h00, 64'h100, 64'd4, 64'h10, 0, 4'd6);
    vec(2'b10, 1, 3'b001, 7'h00, 64'd1, 64'd31,
        64'hFFFF_FFFF_8000_0000, 0, 4'd2);
    vec(2'b10, 1, 3'b101, 7'h00, 64'hFFFF_FFFF_8000_0000, 64'd4,
        64'h0800_0000, 0, 4'd6);
    vec(2'b10, 1, 3'b000, 7'h20, 64'd0, 64'd1,
        64'hFFFF_FFFF_FFFF_FFFF, 0, 4'd1);
    vec(2'b10, 1, 3'b100, 7'h00, 64'h1_0000_0000, 64'h8000_0000,
        64'hFFFF_FFFF_8000_0000, 0, 4'd5);
    vec(2'b01, 0, 3'b101, 7'h00, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
        64'd2, 1, 4'd13);
    vec(2'b01, 0, 3'b111, 7'h00, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
        64'd2, 0, 4'd15);
    vec(2'b01, 0, 3'b001, 7'h00, 64'd4, 64'd3, 64'd1, 1, 4'd11);
    vec(2'b10, 1, 3'b001, 7'h00, 64'd1, 64'd32, 64'd1, 0, 4'd2);

    // Back-to-back: before the edge the previous op is still shown
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].op, vq[i].w, vq[i].f3, vq[i].f7, vq[i].a, vq[i].b);
      #1;
      if (i > 0) chk($sformatf("b2b%0d.hold", i), result, vq[i-1].res);
      tick();
      expect_out($sformatf("b2b%0d", i), 1'b1, vq[i].res, vq[i].z,
                 vq[i].ctl);
    end

    reset = 1'b1;
    drive(vq[4].op, vq[4].w, vq[4].f3, vq[4].f7, vq[4].a, vq[4].b);
    tick();
    expect_out("midreset", 1'b0, 64'd0, 1'b0, 4'd0);

    reset = 1'b0;
    drive(vq[0].op, vq[0].w, vq[0].f3, vq[0].f7, vq[0].a, vq[0].b);
    tick();
    expect_out("resume", 1'b1, vq[0].res, vq[0].z, vq[0].ctl);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
